// File: rtl/digitron_display_arbiter_pkg.sv
// Shared constants and helpers for the six-digit display arbiter.
package digitron_display_arbiter_pkg;

   localparam int DIGITS = 6;
   localparam int NIB_W  = 4;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   localparam logic [DIGITS-1:0] BLANK_RST = 6'b111110;

   // Digit k blanks only when it and every digit above it are zero; digit 0 always lit.
   function automatic logic [DIGITS-1:0] blank_mask(input logic [DIGITS*NIB_W-1:0] word);
      logic [DIGITS-1:0] mask;
      logic              all_zero;
      mask     = '0;
      all_zero = 1'b1;
      for (int k = DIGITS-1; k >= 1; k--) begin
         all_zero = all_zero & (word[k*NIB_W +: NIB_W] == 4'h0);
         mask[k]  = all_zero;
      end
      return mask;
   endfunction

endpackage

// File: rtl/digitron_display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping to 0.
module rr_pick #(
   parameter int N_SRC = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_SRC-1:0] Req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any,
   output logic [PTR_W-1:0] winner
);

   int idx;

   always_comb begin
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 1; i <= N_SRC; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_SRC) idx = idx - N_SRC;
         if (!any && Req[idx]) begin
            any    = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/digitron_display_arbiter.sv
// Round-robin owner of the seven-segment display with a minimum hold per grant.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no hold running; arbitrate every cycle a request is present
//   ST_HOLD | word on screen; counter runs, re-arbitrate at HOLD_TICKS-1
module digitron_display_arbiter
   import digitron_display_arbiter_pkg::*;
#(
   parameter int N_SRC      = 3,
   parameter int DATA_W     = 24,
   parameter int HOLD_TICKS = 50000,
   parameter int CNT_W      = 16
) (
   input  logic                    CLK,
   input  logic                    RSTn,
   input  logic [N_SRC-1:0]        Req,
   input  logic [N_SRC*DATA_W-1:0] Src_Data,
   output logic [N_SRC-1:0]        Grant,
   output logic [N_SRC-1:0]        Ack,
   output logic [DATA_W-1:0]       Disp_Data,
   output logic [DIGITS-1:0]       Disp_Blank,
   output logic                    Disp_Valid
);

   localparam int PTR_W = (N_SRC > 2) ? 2 : 1;
   localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

   logic [0:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [PTR_W-1:0]  ptr;
   logic              any;
   logic [PTR_W-1:0]  winner;
   logic [DATA_W-1:0] win_data;
   logic              hold_end;
   logic              arb;

   rr_pick #(.N_SRC(N_SRC), .PTR_W(PTR_W)) u_rr_pick (
      .Req    (Req),
      .ptr    (ptr),
      .any    (any),
      .winner (winner)
   );

   assign win_data = Src_Data[int'(winner)*DATA_W +: DATA_W];
   assign hold_end = (state == ST_HOLD) && (cnt == CNT_W'(HOLD_TICKS-1));
   assign arb      = (state == ST_IDLE) || hold_end;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ptr        <= PTR_W'(N_SRC-1);
         Grant      <= '0;
         Ack        <= '0;
         Disp_Data  <= '0;
         Disp_Blank <= BLANK_RST;
         Disp_Valid <= 1'b0;
      end else begin
         Ack <= '0;
         if (arb) begin
            cnt <= '0;
            if (any) begin
               state      <= ST_HOLD;
               ptr        <= winner;
               Grant      <= ONE << winner;
               Ack        <= ONE << winner;
               Disp_Data  <= win_data;
               Disp_Blank <= blank_mask(win_data);
               Disp_Valid <= 1'b1;
            end else begin
               // Display keeps the last word; only the hold bookkeeping stops.
               state <= ST_IDLE;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_digitron_display_arbiter.sv
// Directed plus random bench for the display arbiter against a cycle-level reference model.
module tb_digitron_display_arbiter;

   localparam int N    = 3;
   localparam int DW   = 24;
   localparam int HOLD = 4;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic [N-1:0]  Req = '0;
   logic [N*DW-1:0] Src_Data = '0;
   logic [N-1:0]  Grant;
   logic [N-1:0]  Ack;
   logic [DW-1:0] Disp_Data;
   logic [5:0]    Disp_Blank;
   logic          Disp_Valid;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   bit            m_busy;
   int            m_elapsed;
   int            m_last;
   logic [N-1:0]  m_grant, m_ack;
   logic [DW-1:0] m_data;
   logic [5:0]    m_blank;
   logic          m_valid;

   always #5 CLK = ~CLK;

   digitron_display_arbiter #(.N_SRC(N), .DATA_W(DW), .HOLD_TICKS(HOLD), .CNT_W(16)) dut (
      .CLK(CLK), .RSTn(RSTn), .Req(Req), .Src_Data(Src_Data),
      .Grant(Grant), .Ack(Ack), .Disp_Data(Disp_Data),
      .Disp_Blank(Disp_Blank), .Disp_Valid(Disp_Valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ref_blank(input logic [DW-1:0] w);
      int lz;
      lz = 0;
      while (lz < 5 && w[DW-1-4*lz -: 4] == 4'h0) lz++;
      return 6'(((1 << lz) - 1) << (6 - lz));
   endfunction

   task automatic model_reset();
      m_busy = 0; m_elapsed = 0; m_last = N-1;
      m_grant = '0; m_ack = '0; m_data = '0; m_blank = 6'b111110; m_valid = 0;
   endtask

   task automatic model_step();
      int w;
      m_ack = '0;
      if (!RSTn) begin
         model_reset();
      end else if (m_busy && m_elapsed < HOLD-1) begin
         m_elapsed++;
      end else begin
         w = -1;
         for (int i = 1; i <= N && w < 0; i++)
            if (Req[(m_last + i) % N]) w = (m_last + i) % N;
         if (w >= 0) begin
            m_last    = w;
            m_grant   = N'(1 << w);
            m_ack     = N'(1 << w);
            m_data    = Src_Data[w*DW +: DW];
            m_blank   = ref_blank(m_data);
            m_valid   = 1;
            m_busy    = 1;
            m_elapsed = 0;
         end else begin
            m_busy = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".grant"}, 32'(Grant), 32'(m_grant));
      chk({tag, ".ack"},   32'(Ack),   32'(m_ack));
      chk({tag, ".data"},  32'(Disp_Data), 32'(m_data));
      chk({tag, ".blank"}, 32'(Disp_Blank), 32'(m_blank));
      chk({tag, ".valid"}, 32'(Disp_Valid), 32'(m_valid));
   endtask

   task automatic cycle(input string tag);
      @(posedge CLK);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn = 1'b0;
      cycle("rst");
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   initial begin
      int ack_val [4];
      int ack_cyc [4];
      int n_ack;

      model_reset();
      cycle("rst0");
      @(negedge CLK);
      RSTn = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 20; i++) cycle("idle");
      chk("idle.blank_const", 32'(Disp_Blank), 32'h3E);

      // 2: single request
      @(negedge CLK);
      Src_Data[0 +: DW] = 24'h000123;
      Req = 3'b001;
      cycle("single");
      chk("single.ack_const", 32'(Ack), 32'h1);
      chk("single.blank_const", 32'(Disp_Blank), 32'h38);
      chk("single.data_const", 32'(Disp_Data), 32'h000123);
      @(negedge CLK);
      Req = '0;
      cycle("single");
      chk("single.ack_pulse", 32'(Ack), 32'h0);
      for (int i = 0; i < 5; i++) cycle("single");

      // 3: all three requesting
      do_reset();
      Src_Data = {24'h3, 24'h2, 24'h1};
      Req = 3'b111;
      n_ack = 0;
      for (int c = 0; c < 13; c++) begin
         cycle("rr");
         if (Ack != 0 && n_ack < 4) begin
            ack_val[n_ack] = int'(Ack);
            ack_cyc[n_ack] = c;
            n_ack++;
         end
      end
      chk("rr.count", 32'(n_ack), 32'd4);
      chk("rr.ack0", 32'(ack_val[0]), 32'h1);
      chk("rr.ack1", 32'(ack_val[1]), 32'h2);
      chk("rr.ack2", 32'(ack_val[2]), 32'h4);
      chk("rr.ack3", 32'(ack_val[3]), 32'h1);
      chk("rr.gap", 32'(ack_cyc[3] - ack_cyc[0]), 32'd12);

      // 4: requester drops right after its grant
      do_reset();
      Src_Data = {24'h0, 24'h00ABCD, 24'h0};
      Req = 3'b010;
      cycle("drop");
      cycle("drop");
      @(negedge CLK);
      Req = '0;
      for (int i = 0; i < 6; i++) begin
         cycle("drop");
         chk("drop.grant_const", 32'(Grant), 32'h2);
         chk("drop.data_const", 32'(Disp_Data), 32'h00ABCD);
      end

      // 5: blank mask extremes
      @(negedge CLK);
      Src_Data[0 +: DW] = 24'h000000;
      Req = 3'b001;
      cycle("zero");
      chk("zero.blank_const", 32'(Disp_Blank), 32'h3E);
      @(negedge CLK);
      Req = '0;
      for (int i = 0; i < 5; i++) cycle("zero");
      @(negedge CLK);
      Src_Data[0 +: DW] = 24'h100000;
      Req = 3'b001;
      cycle("full");
      chk("full.blank_const", 32'(Disp_Blank), 32'h00);

      // 6: reset mid-hold
      @(negedge CLK);
      Req = '0;
      for (int i = 0; i < 5; i++) cycle("mid");
      @(negedge CLK);
      Req = 3'b100;
      Src_Data[2*DW +: DW] = 24'h0F00F0;
      cycle("mid");
      cycle("mid");
      #2;
      RSTn = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge CLK);
      RSTn = 1'b1;
      Req = 3'b111;
      cycle("after_rst");
      chk("after_rst.ack_const", 32'(Ack), 32'h1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         Req = N'($urandom_range(0, 7));
         for (int s = 0; s < N; s++)
            Src_Data[s*DW +: DW] = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 255));
         RSTn = ($urandom_range(0, 59) != 0);
         cycle("rand");
      end
      @(negedge CLK);
      RSTn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
